pipeline_hazard_ctrl: RTL and testbench

//   Central stall/flush sequencer for the 5-stage MIPS pipeline. Watches IF/ID, ID/EX and EX/MEM

---
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, dmem wait states, jump squash, halt drain.
// Control outputs are combinational from state + inputs; halted/dmem_err/stall_cycles are registered.
module pipeline_hazard_ctrl #(
    parameter int CNT_W     = 32,
    parameter int MAX_WAIT  = 16,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_if_id,
    input  logic [4:0]       rt_if_id,
    input  logic             MemRead_id_ex,
    input  logic [4:0]       rt_id_ex,
    input  logic             MemRead_ex_mem,
    input  logic             MemWrite_ex_mem,
    input  logic [1:0]       Jump_ex_mem,
    input  logic             halt_ex_mem,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             dmem_req,
    output logic             halted,
    output logic             dmem_err,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WW = $clog2(MAX_WAIT) + 1;
    localparam int DW = $clog2(DRAIN_CYC) + 1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

    state_t         state, state_nxt;
    logic [WW-1:0]  wait_cnt, wait_nxt;
    logic [DW-1:0]  drain_cnt, drain_nxt;
    logic           err_set;
    logic           mem_acc;
    logic           load_use;

    assign mem_acc  = MemRead_ex_mem | MemWrite_ex_mem;
    assign load_use = MemRead_id_ex && (rt_id_ex != 5'd0) &&
                      ((rt_id_ex == rs_if_id) || (rt_id_ex == rt_if_id));

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        dmem_req      = 1'b0;
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        drain_nxt     = drain_cnt;
        err_set       = 1'b0;
        case (state)
            RUN: begin
                dmem_req = mem_acc;
                if (mem_acc && !dmem_ack) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    state_nxt     = MEM_WAIT;
                    wait_nxt      = WW'(1);
                end else if (halt_ex_mem) begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_nxt   = DRAIN;
                    drain_nxt   = '0;
                end else if (Jump_ex_mem != 2'b00) begin
                    // Squashing the wrong-path instructions also discards any load-use hazard.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmem_req = mem_acc;
                if (dmem_ack) begin
                    state_nxt = RUN;
                end else begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                        err_set   = 1'b1;
                        state_nxt = HALTED;
                    end else begin
                        wait_nxt = wait_cnt + WW'(1);
                    end
                end
            end
            DRAIN: begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                drain_nxt   = drain_cnt + DW'(1);
                if (drain_cnt == DW'(DRAIN_CYC - 1))
                    state_nxt = HALTED;
            end
            HALTED: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            drain_cnt    <= '0;
            halted       <= 1'b0;
            dmem_err     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            drain_cnt <= drain_nxt;
            halted    <= halted | (state_nxt == HALTED);
            dmem_err  <= dmem_err | err_set;
            if ((state == RUN || state == MEM_WAIT) && !pc_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a counter-based reference model.
module tb_pipeline_hazard_ctrl;
    localparam int MAX_WAIT  = 16;
    localparam int DRAIN_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_if_id, rt_if_id, rt_id_ex;
    logic        MemRead_id_ex, MemRead_ex_mem, MemWrite_ex_mem, halt_ex_mem, dmem_ack;
    logic [1:0]  Jump_ex_mem;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, mem_wb_bubble;
    logic        if_id_flush, id_ex_flush, dmem_req, halted, dmem_err;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(32), .MAX_WAIT(MAX_WAIT), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst(rst),
        .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
        .MemRead_id_ex(MemRead_id_ex), .rt_id_ex(rt_id_ex),
        .MemRead_ex_mem(MemRead_ex_mem), .MemWrite_ex_mem(MemWrite_ex_mem),
        .Jump_ex_mem(Jump_ex_mem), .halt_ex_mem(halt_ex_mem), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .dmem_req(dmem_req),
        .halted(halted), .dmem_err(dmem_err), .stall_cycles(stall_cycles)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: unacked-cycle count, drain cycles remaining, sticky flags.
    int          m_waited;
    int          m_drain_left;
    bit          m_halted, m_err;
    longint      m_stall;
    logic [8:0]  e_ctrl;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // e_ctrl = {pc_en,if_id_en,id_ex_en,ex_mem_en,id_ex_bubble,mem_wb_bubble,if_id_flush,id_ex_flush,dmem_req}
    task automatic compute_exp();
        bit acc, lu;
        acc = MemRead_ex_mem || MemWrite_ex_mem;
        lu  = MemRead_id_ex && rt_id_ex != 0 && (rt_id_ex == rs_if_id || rt_id_ex == rt_if_id);
        if (m_halted)                e_ctrl = 9'b0000_0000_0;
        else if (m_drain_left > 0)   e_ctrl = 9'b0111_0011_0;
        else if (m_waited > 0)       e_ctrl = dmem_ack ? {8'b1111_0000, acc} : {8'b0000_0100, acc};
        else if (acc && !dmem_ack)   e_ctrl = {8'b0000_0100, acc};
        else if (halt_ex_mem)        e_ctrl = {8'b0111_0011, acc};
        else if (Jump_ex_mem != 0)   e_ctrl = {8'b1111_0011, acc};
        else if (lu)                 e_ctrl = {8'b0011_1000, acc};
        else                         e_ctrl = {8'b1111_0000, acc};
    endtask

    task automatic update_model();
        bit acc;
        acc = MemRead_ex_mem || MemWrite_ex_mem;
        if (rst) begin
            m_waited = 0; m_drain_left = 0; m_halted = 0; m_err = 0; m_stall = 0;
            return;
        end
        if (!m_halted && m_drain_left == 0 && e_ctrl[8] == 1'b0 && m_stall != 64'hFFFF_FFFF)
            m_stall++;
        if (m_halted) begin
        end else if (m_drain_left > 0) begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1;
        end else if (m_waited > 0) begin
            if (dmem_ack) m_waited = 0;
            else if (m_waited == MAX_WAIT - 1) begin
                m_err = 1; m_halted = 1; m_waited = 0;
            end else m_waited++;
        end else if (acc && !dmem_ack) begin
            m_waited = 1;
        end else if (halt_ex_mem) begin
            m_drain_left = DRAIN_CYC;
        end
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic run_cycle();
        #1;
        compute_exp();
        chk("ctrl", {pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, mem_wb_bubble,
                     if_id_flush, id_ex_flush, dmem_req}, e_ctrl);
        chk("halted", halted, m_halted);
        chk("dmem_err", dmem_err, m_err);
        chk("stall", stall_cycles, m_stall);
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rs_if_id = 0; rt_if_id = 0; rt_id_ex = 0; MemRead_id_ex = 0;
        MemRead_ex_mem = 0; MemWrite_ex_mem = 0; Jump_ex_mem = 0; halt_ex_mem = 0; dmem_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        run_cycle();
        rst = 0;
    endtask

    initial begin
        int halted_for;
        m_waited = 0; m_drain_left = 0; m_halted = 0; m_err = 0; m_stall = 0;
        clear_inputs();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        run_cycle();
        rst = 0;
        #1;
        chk("rst_halted", halted, 0);
        chk("rst_err", dmem_err, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_pc_en", pc_en, 1);

        // Load-use stall for one cycle, and the rt==0 exemption.
        MemRead_id_ex = 1; rt_id_ex = 5; rs_if_id = 5;
        #1;
        chk("lu_stall", {pc_en, if_id_en, id_ex_bubble}, 3'b001);
        run_cycle();
        clear_inputs();
        run_cycle();
        MemRead_id_ex = 1; rt_id_ex = 0; rs_if_id = 0; rt_if_id = 0;
        #1;
        chk("lu_r0", {pc_en, if_id_en, id_ex_bubble}, 3'b110);
        run_cycle();

        // Three unacked dmem cycles, released on the ack cycle.
        do_reset();
        MemRead_ex_mem = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_bubble", {pc_en, mem_wb_bubble, dmem_req}, 3'b011);
            run_cycle();
        end
        dmem_ack = 1;
        #1;
        chk("mw_release", {pc_en, ex_mem_en, mem_wb_bubble}, 3'b110);
        run_cycle();
        clear_inputs();
        #1;
        chk("mw_stall_cnt", stall_cycles, 3);
        run_cycle();

        // Store never acknowledged: error and halt after the 16th cycle.
        do_reset();
        MemWrite_ex_mem = 1;
        for (int i = 0; i < MAX_WAIT - 1; i++) run_cycle();
        #1;
        chk("to_not_yet", {dmem_err, halted}, 2'b00);
        run_cycle();
        #1;
        chk("to_err", {dmem_err, halted}, 2'b11);
        chk("to_req", dmem_req, 0);
        run_cycle();

        // Jump masks a simultaneous load-use hazard.
        do_reset();
        Jump_ex_mem = 2'b01; MemRead_id_ex = 1; rt_id_ex = 7; rt_if_id = 7;
        #1;
        chk("jmp_lu", {if_id_flush, id_ex_flush, pc_en, id_ex_bubble}, 4'b1110);
        run_cycle();

        // Halt: two drain cycles, then stopped until reset.
        do_reset();
        halt_ex_mem = 1;
        run_cycle();
        halt_ex_mem = 0;
        for (int i = 0; i < DRAIN_CYC; i++) begin
            #1;
            chk("drain", {pc_en, if_id_flush, id_ex_flush, ex_mem_en, halted}, 5'b01110);
            run_cycle();
        end
        #1;
        chk("halt_stop", {halted, pc_en, if_id_en, id_ex_en, ex_mem_en}, 5'b10000);
        run_cycle();
        run_cycle();

        // Reset in the middle of a memory wait.
        do_reset();
        MemRead_ex_mem = 1;
        run_cycle();
        run_cycle();
        rst = 1;
        run_cycle();
        rst = 0;
        dmem_ack = 1;
        #1;
        chk("rmw_state", {pc_en, mem_wb_bubble, dmem_req}, 3'b101);
        chk("rmw_stall", stall_cycles, 0);
        chk("rmw_err", dmem_err, 0);
        run_cycle();

        // Randomized traffic.
        do_reset();
        halted_for = 0;
        for (int c = 0; c < 4000; c++) begin
            rs_if_id        = 5'($urandom_range(0, 7));
            rt_if_id        = 5'($urandom_range(0, 7));
            rt_id_ex        = 5'($urandom_range(0, 7));
            MemRead_id_ex   = ($urandom_range(0, 2) == 0);
            MemRead_ex_mem  = ($urandom_range(0, 4) == 0);
            MemWrite_ex_mem = ($urandom_range(0, 6) == 0);
            Jump_ex_mem     = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            halt_ex_mem     = ($urandom_range(0, 79) == 0);
            dmem_ack        = ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 5 : 1));
            halted_for      = m_halted ? halted_for + 1 : 0;
            rst             = ($urandom_range(0, 149) == 0) || (halted_for > 4);
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
